weight_update_feeder: RTL and testbench



---
 rtl/weight_update_feeder_pkg.sv | 28 ++
 rtl/weight_update_feeder_slice_packer.sv | 31 +++
 rtl/weight_update_feeder.sv | 215 +++++++++++++++++++++
 tb/tb_weight_update_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_update_feeder_pkg.sv
// Shared sizing constants and FSM state encoding for the weight update feeder.
package weight_update_feeder_pkg;

   localparam int WUF_DATA_WIDTH              = 16;
   localparam int WUF_KERNEL_SIZE_MAX         = 3;
   localparam int WUF_PARA_KERNEL             = 2;
   localparam int WUF_DEPTH_MAX               = 256;
   localparam int WUF_WEIGHT_WRITE_ADDR_WIDTH = 10;
   localparam int WUF_KERNEL_NUM_WIDTH        = 9;
   localparam int WUF_KERNEL_SIZE_WIDTH       = 6;
   localparam int WUF_SRC_ADDR_WIDTH          = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPT,
      ST_BEAT,
      ST_NEXT,
      ST_GROUP,
      ST_DONE
   } feeder_state_t;

   // Width of a slot index; a single-slot configuration still needs one bit.
   function automatic int slot_width(input int slots);
      return (slots > 1) ? $clog2(slots) : 1;
   endfunction

endpackage

// File: rtl/weight_update_feeder_slice_packer.sv
// Assembles one beat of PARA_KERNEL kernel slices as read data returns.
module weight_update_feeder_slice_packer
   import weight_update_feeder_pkg::*;
#(
   parameter int SLICE_WIDTH = WUF_KERNEL_SIZE_MAX * WUF_KERNEL_SIZE_MAX * WUF_DATA_WIDTH,
   parameter int SLOTS       = WUF_PARA_KERNEL,
   parameter int SLOT_W      = slot_width(WUF_PARA_KERNEL)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         capture_en,
   input  logic [SLOT_W-1:0]            capture_slot,
   input  logic [SLICE_WIDTH-1:0]       capture_data,
   output logic [SLICE_WIDTH*SLOTS-1:0] packed_data
);

   // Drop each returning slice into its slot; slots never read keep their cleared zero value.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         packed_data <= '0;
      end else if (capture_en) begin
         for (int k = 0; k < SLOTS; k++) begin
            if (capture_slot == SLOT_W'(k)) begin
               packed_data[k*SLICE_WIDTH +: SLICE_WIDTH] <= capture_data;
            end
         end
      end
   end

endmodule

// File: rtl/weight_update_feeder.sv
// Streams kernel groups from a backing weight store into the conv engine's weight RAM.
module weight_update_feeder
   import weight_update_feeder_pkg::*;
#(
   parameter int DATA_WIDTH              = WUF_DATA_WIDTH,
   parameter int KERNEL_SIZE_MAX         = WUF_KERNEL_SIZE_MAX,
   parameter int PARA_KERNEL             = WUF_PARA_KERNEL,
   parameter int DEPTH_MAX               = WUF_DEPTH_MAX,
   parameter int WEIGHT_WRITE_ADDR_WIDTH = WUF_WEIGHT_WRITE_ADDR_WIDTH,
   parameter int KERNEL_NUM_WIDTH        = WUF_KERNEL_NUM_WIDTH,
   parameter int KERNEL_SIZE_WIDTH       = WUF_KERNEL_SIZE_WIDTH,
   parameter int SRC_ADDR_WIDTH          = WUF_SRC_ADDR_WIDTH
) (
   input  logic                                                          clk,
   input  logic                                                          rst,
   input  logic                                                          start,
   input  logic [KERNEL_SIZE_WIDTH-1:0]                                  fm_depth,
   input  logic [KERNEL_NUM_WIDTH-1:0]                                   kernel_num,
   input  logic                                                          update_weight_ram,
   input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                update_weight_ram_addr,
   output logic                                                          src_rd_en,
   output logic [SRC_ADDR_WIDTH-1:0]                                     src_rd_addr,
   input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0]         src_rd_data,
   output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
   output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                write_weight_data_addr,
   output logic                                                          weight_wr,
   output logic                                                          weight_data_done,
   output logic                                                          busy,
   output logic                                                          all_kernels_sent
);

   localparam int SLICE_WIDTH = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
   localparam int BASE_W      = WEIGHT_WRITE_ADDR_WIDTH * PARA_KERNEL;
   localparam int SLOT_W      = slot_width(PARA_KERNEL);
   localparam int KIDX_W      = KERNEL_NUM_WIDTH + 1;
   localparam int SLICE_EXT   = KERNEL_SIZE_WIDTH + 1;

   feeder_state_t                  state, state_nxt;
   logic [SLOT_W-1:0]              slot;
   logic [KERNEL_SIZE_WIDTH-1:0]   slice;
   logic [KERNEL_SIZE_WIDTH-1:0]   fm_depth_q;
   logic [KERNEL_NUM_WIDTH-1:0]    kernel_num_q;
   logic [SRC_ADDR_WIDTH-1:0]      kbase;
   logic [SRC_ADDR_WIDTH-1:0]      grp_base;
   logic [KIDX_W-1:0]              grp_kidx;
   logic [BASE_W-1:0]              base_q;
   logic [BASE_W-1:0]              pend_addr_q;
   logic                           preload_q;
   logic                           pending_q;
   logic                           upd_d;
   logic                           cap_valid;
   logic [SLOT_W-1:0]              cap_slot;
   logic [SLICE_WIDTH*PARA_KERNEL-1:0] packed_beat;

   logic [KIDX_W-1:0]              kidx;
   logic [SLICE_EXT-1:0]           slice_inc;
   logic                           rd_en;
   logic                           upd_edge;
   logic                           last_group;
   logic                           slice_last;
   logic                           more_preload;
   logic                           launch;
   logic [BASE_W-1:0]              launch_addr;

   assign kidx         = grp_kidx + KIDX_W'(slot);
   assign rd_en        = (state == ST_READ) && (kidx < {1'b0, kernel_num_q});
   assign upd_edge     = update_weight_ram && !upd_d;
   assign last_group   = (grp_kidx + KIDX_W'(PARA_KERNEL)) >= {1'b0, kernel_num_q};
   assign slice_inc    = {1'b0, slice} + SLICE_EXT'(1);
   assign slice_last   = slice_inc >= {1'b0, fm_depth_q};
   assign more_preload = preload_q && !last_group;
   assign launch       = (state == ST_IDLE) && !all_kernels_sent && (pending_q || upd_edge);
   assign launch_addr  = pending_q ? pend_addr_q : update_weight_ram_addr;

   assign src_rd_en    = rd_en;
   assign src_rd_addr  = rd_en ? (kbase + SRC_ADDR_WIDTH'(slice)) : '0;
   assign busy         = (state != ST_IDLE);

   weight_update_feeder_slice_packer #(
      .SLICE_WIDTH (SLICE_WIDTH),
      .SLOTS       (PARA_KERNEL),
      .SLOT_W      (SLOT_W)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear        (start || (state == ST_BEAT)),
      .capture_en   (cap_valid),
      .capture_slot (cap_slot),
      .capture_data (src_rd_data),
      .packed_data  (packed_beat)
   );

   // State register; start from any state restarts the preload.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequencing: PARA_KERNEL reads, one capture cycle, then beat and slice advance.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (launch) state_nxt = ST_READ;
         ST_READ:  if (slot == SLOT_W'(PARA_KERNEL - 1)) state_nxt = ST_CAPT;
         ST_CAPT:  state_nxt = ST_BEAT;
         ST_BEAT:  state_nxt = ST_NEXT;
         ST_NEXT:  state_nxt = slice_last ? ST_GROUP : ST_READ;
         ST_GROUP: state_nxt = more_preload ? ST_READ : ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (start) begin
         state_nxt = ST_READ;
      end
   end

   // Counters, read-address accumulator, request bookkeeping and registered beat outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         slot                   <= '0;
         slice                  <= '0;
         fm_depth_q             <= '0;
         kernel_num_q           <= '0;
         kbase                  <= '0;
         grp_base               <= '0;
         grp_kidx               <= '0;
         base_q                 <= '0;
         pend_addr_q            <= '0;
         preload_q              <= 1'b0;
         pending_q              <= 1'b0;
         upd_d                  <= 1'b0;
         cap_valid              <= 1'b0;
         cap_slot               <= '0;
         weight_data            <= '0;
         write_weight_data_addr <= '0;
         weight_wr              <= 1'b0;
         weight_data_done       <= 1'b0;
         all_kernels_sent       <= 1'b0;
      end else if (start) begin
         fm_depth_q       <= fm_depth;
         kernel_num_q     <= kernel_num;
         slot             <= '0;
         slice            <= '0;
         kbase            <= '0;
         grp_base         <= '0;
         grp_kidx         <= '0;
         base_q           <= '0;
         preload_q        <= 1'b1;
         pending_q        <= 1'b0;
         upd_d            <= update_weight_ram;
         cap_valid        <= 1'b0;
         cap_slot         <= '0;
         weight_wr        <= 1'b0;
         weight_data_done <= 1'b0;
         all_kernels_sent <= 1'b0;
      end else begin
         upd_d     <= update_weight_ram;
         weight_wr <= 1'b0;
         cap_valid <= rd_en;
         cap_slot  <= slot;
         if (upd_edge && (state != ST_IDLE) && !pending_q) begin
            pending_q   <= 1'b1;
            pend_addr_q <= update_weight_ram_addr;
         end
         case (state)
            ST_IDLE: begin
               pending_q <= 1'b0;
               if (launch) begin
                  base_q           <= launch_addr;
                  weight_data_done <= 1'b0;
                  slot             <= '0;
                  slice            <= '0;
               end
            end
            ST_READ: begin
               kbase <= kbase + SRC_ADDR_WIDTH'(fm_depth_q);
               slot  <= (slot == SLOT_W'(PARA_KERNEL - 1)) ? '0 : slot + SLOT_W'(1);
            end
            ST_BEAT: begin
               weight_data            <= packed_beat;
               write_weight_data_addr <= base_q + BASE_W'(slice);
               weight_wr              <= 1'b1;
            end
            ST_NEXT: begin
               if (slice_last) begin
                  grp_base <= kbase;
               end else begin
                  slice <= slice_inc[KERNEL_SIZE_WIDTH-1:0];
                  kbase <= grp_base;
               end
            end
            ST_GROUP: begin
               grp_kidx <= grp_kidx + KIDX_W'(PARA_KERNEL);
               slice    <= '0;
               if (last_group) begin
                  all_kernels_sent <= 1'b1;
               end
               if (more_preload) begin
                  preload_q <= 1'b0;
                  base_q    <= BASE_W'(DEPTH_MAX);
               end
            end
            ST_DONE: begin
               weight_data_done <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_update_feeder.sv
// Self-checking bench: behavioural store model, scoreboard queues and a table of layer transactions.
module tb_weight_update_feeder;

   localparam int P   = 2;
   localparam int SW  = 9 * 16;
   localparam int BW  = SW * P;
   localparam int AW  = 20;

   typedef struct {
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } beat_t;

   typedef struct {
      bit            is_start;
      int            fm;
      int            kn;
      logic [AW-1:0] addr;
      bit            exp_all;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [5:0]     fm_depth = '0;
   logic [8:0]     kernel_num = '0;
   logic           update_weight_ram = 1'b0;
   logic [AW-1:0]  update_weight_ram_addr = '0;
   logic           src_rd_en;
   logic [15:0]    src_rd_addr;
   logic [SW-1:0]  src_rd_data = '0;
   logic [BW-1:0]  weight_data;
   logic [AW-1:0]  write_weight_data_addr;
   logic           weight_wr;
   logic           weight_data_done;
   logic           busy;
   logic           all_kernels_sent;

   int             n_cmp = 0;
   int             n_bad = 0;
   int             rd_seen = 0;
   int             wr_seen = 0;
   logic [15:0]    exp_rd[$];
   beat_t          exp_beat[$];
   beat_t          wr_log[$];
   int             mdl_depth, mdl_num, mdl_group;
   bit             mdl_all;
   vec_t           vecs[7];

   always #5 clk = ~clk;

   weight_update_feeder dut (
      .clk                    (clk),
      .rst                    (rst),
      .start                  (start),
      .fm_depth               (fm_depth),
      .kernel_num             (kernel_num),
      .update_weight_ram      (update_weight_ram),
      .update_weight_ram_addr (update_weight_ram_addr),
      .src_rd_en              (src_rd_en),
      .src_rd_addr            (src_rd_addr),
      .src_rd_data            (src_rd_data),
      .weight_data            (weight_data),
      .write_weight_data_addr (write_weight_data_addr),
      .weight_wr              (weight_wr),
      .weight_data_done       (weight_data_done),
      .busy                   (busy),
      .all_kernels_sent       (all_kernels_sent)
   );

   function automatic logic [SW-1:0] mk_slice(input logic [15:0] a);
      logic [SW-1:0] s;
      for (int e = 0; e < 9; e++) s[e*16 +: 16] = 16'h3c00 + a + 16'(e * 256);
      return s;
   endfunction

   function automatic logic [SW-1:0] junk();
      logic [SW-1:0] s;
      for (int e = 0; e < 9; e++) s[e*16 +: 16] = 16'($urandom);
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic void push_group(input int g, input logic [AW-1:0] base);
      for (int s = 0; s < mdl_depth; s++) begin
         beat_t b;
         b.addr = base + AW'(s);
         b.data = '0;
         for (int k = 0; k < P; k++) begin
            int kidx = g * P + k;
            if (kidx < mdl_num) begin
               int a = kidx * mdl_depth + s;
               exp_rd.push_back(16'(a));
               b.data[k*SW +: SW] = mk_slice(16'(a));
            end
         end
         exp_beat.push_back(b);
      end
   endfunction

   function automatic void model_start(input int fm, input int kn);
      exp_rd.delete();
      exp_beat.delete();
      mdl_depth = fm;
      mdl_num   = kn;
      push_group(0, '0);
      mdl_group = 1;
      mdl_all   = (P >= kn);
      if (kn > P) begin
         push_group(1, AW'(256));
         mdl_group = 2;
         mdl_all   = (2 * P >= kn);
      end
   endfunction

   // Backing store: registered read, garbage on cycles without a read.
   always @(posedge clk) begin
      if (src_rd_en === 1'b1) src_rd_data <= mk_slice(src_rd_addr);
      else                    src_rd_data <= junk();
   end

   // Scoreboard: every read and every beat must match the next expected entry.
   always @(negedge clk) begin
      logic [15:0] ea;
      beat_t       b;
      if (src_rd_en === 1'b1) begin
         rd_seen++;
         if (exp_rd.size() == 0) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL unexpected_read: got addr %0h expected no read", src_rd_addr);
         end else begin
            ea = exp_rd.pop_front();
            checkOutput("rd_addr", BW'(src_rd_addr), BW'(ea));
         end
      end
      if (weight_wr === 1'b1) begin
         wr_seen++;
         b.addr = write_weight_data_addr;
         b.data = weight_data;
         wr_log.push_back(b);
         if (exp_beat.size() == 0) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL unexpected_beat: got addr %0h expected no beat", write_weight_data_addr);
         end else begin
            b = exp_beat.pop_front();
            checkOutput("beat_addr", BW'(write_weight_data_addr), BW'(b.addr));
            checkOutput("beat_data", weight_data, b.data);
         end
      end
   end

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge clk); #1;
         if (weight_data_done && !busy && exp_beat.size() == 0) ok = 1'b1;
      end
      checkOutput({name, "_done_seen"}, BW'(ok), BW'(1));
   endtask

   task automatic applyStimulus(input vec_t v, input string name);
      int  rd0, wr0;
      bit  accept;
      if (v.is_start) begin
         model_start(v.fm, v.kn);
         @(negedge clk);
         fm_depth   = 6'(v.fm);
         kernel_num = 9'(v.kn);
         start      = 1'b1;
         @(negedge clk);
         start = 1'b0;
         checkOutput({name, "_done_fall"}, BW'(weight_data_done), BW'(0));
      end else begin
         accept = !mdl_all;
         if (accept) begin
            push_group(mdl_group, v.addr);
            mdl_all = ((mdl_group + 1) * P >= mdl_num);
            mdl_group++;
         end
         rd0 = rd_seen;
         wr0 = wr_seen;
         @(negedge clk);
         update_weight_ram_addr = v.addr;
         update_weight_ram      = 1'b1;
         @(negedge clk);
         checkOutput({name, "_done_after_edge"}, BW'(weight_data_done), BW'(!accept));
         @(negedge clk);
         update_weight_ram = 1'b0;
         if (!accept) begin
            repeat (20) @(negedge clk);
            #1;
            checkOutput({name, "_no_reads"}, BW'(rd_seen - rd0), BW'(0));
            checkOutput({name, "_no_beats"}, BW'(wr_seen - wr0), BW'(0));
            checkOutput({name, "_done_held"}, BW'(weight_data_done), BW'(1));
         end
      end
      wait_done(name);
   endtask

   task automatic checkIdle(input string name, input bit exp_all);
      checkOutput({name, "_all_sent"}, BW'(all_kernels_sent), BW'(exp_all));
      checkOutput({name, "_busy"}, BW'(busy), BW'(0));
      checkOutput({name, "_rd_left"}, BW'(exp_rd.size()), BW'(0));
      checkOutput({name, "_beat_left"}, BW'(exp_beat.size()), BW'(0));
   endtask

   task automatic check_zero(input string name);
      checkOutput({name, "_rd_en"}, BW'(src_rd_en), BW'(0));
      checkOutput({name, "_rd_addr"}, BW'(src_rd_addr), BW'(0));
      checkOutput({name, "_wdata"}, weight_data, BW'(0));
      checkOutput({name, "_waddr"}, BW'(write_weight_data_addr), BW'(0));
      checkOutput({name, "_wr"}, BW'(weight_wr), BW'(0));
      checkOutput({name, "_done"}, BW'(weight_data_done), BW'(0));
      checkOutput({name, "_busy"}, BW'(busy), BW'(0));
      checkOutput({name, "_all"}, BW'(all_kernels_sent), BW'(0));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  rd0;
      bit  ok;

      vecs[0] = '{1'b1, 2, 6, 20'd0,   1'b0};
      vecs[1] = '{1'b0, 0, 0, 20'd0,   1'b1};
      vecs[2] = '{1'b0, 0, 0, 20'd0,   1'b1};
      vecs[3] = '{1'b1, 1, 3, 20'd0,   1'b1};
      vecs[4] = '{1'b1, 3, 5, 20'd0,   1'b0};
      vecs[5] = '{1'b0, 0, 0, 20'd512, 1'b1};
      vecs[6] = '{1'b1, 1, 1, 20'd0,   1'b1};

      $display("[TB] reset phase");
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_zero("reset");
      end
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         wr_log.delete();
         rd0 = rd_seen;
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         checkIdle($sformatf("vec%0d", i), vecs[i].exp_all);
         if (i == 0) begin
            if (wr_log.size() == 4) begin
               checkOutput("pre_beat0_addr", BW'(wr_log[0].addr), BW'(0));
               checkOutput("pre_beat1_addr", BW'(wr_log[1].addr), BW'(1));
               checkOutput("pre_beat2_addr", BW'(wr_log[2].addr), BW'(256));
               checkOutput("pre_beat3_addr", BW'(wr_log[3].addr), BW'(257));
               checkOutput("pre_beat0_slot0", BW'(wr_log[0].data[15:0]), BW'(16'h3c00));
               checkOutput("pre_beat0_slot1", BW'(wr_log[0].data[SW +: 16]), BW'(16'h3c02));
            end else begin
               checkOutput("pre_beat_count", BW'(wr_log.size()), BW'(4));
            end
         end
         if (i == 3) begin
            checkOutput("odd_read_count", BW'(rd_seen - rd0), BW'(3));
            if (wr_log.size() == 2) begin
               checkOutput("odd_beat_addr", BW'(wr_log[1].addr), BW'(256));
               checkOutput("odd_slot0", BW'(wr_log[1].data[15:0]), BW'(16'h3c02));
               checkOutput("odd_slot1", BW'(wr_log[1].data[SW +: SW]), BW'(0));
            end else begin
               checkOutput("odd_beat_count", BW'(wr_log.size()), BW'(2));
            end
         end
      end

      $display("[TB] pending request while busy");
      model_start(2, 8);
      @(negedge clk);
      fm_depth = 6'd2; kernel_num = 9'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      update_weight_ram_addr = 20'd0;
      update_weight_ram      = 1'b1;
      @(negedge clk);
      checkOutput("pend_busy", BW'(busy), BW'(1));
      @(negedge clk);
      update_weight_ram = 1'b0;
      repeat (2) @(negedge clk);
      update_weight_ram_addr = 20'd512;
      update_weight_ram      = 1'b1;
      @(negedge clk);
      update_weight_ram = 1'b0;
      push_group(2, 20'd0);
      mdl_group = 3;
      wait_done("pend");
      repeat (20) @(negedge clk);
      checkIdle("pend", 1'b0);
      checkOutput("pend_done_held", BW'(weight_data_done), BW'(1));

      $display("[TB] abort mid-preload");
      model_start(2, 6);
      rd0 = rd_seen;
      @(negedge clk);
      fm_depth = 6'd2; kernel_num = 9'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk); #1;
         if (rd_seen >= rd0 + 3) ok = 1'b1;
      end
      checkOutput("abort_reads_seen", BW'(ok), BW'(1));
      @(negedge clk);
      start = 1'b1;
      #2;
      model_start(2, 6);
      @(negedge clk);
      start = 1'b0;
      checkOutput("abort_restart_en", BW'(src_rd_en), BW'(1));
      checkOutput("abort_restart_addr", BW'(src_rd_addr), BW'(0));
      checkOutput("abort_done_low", BW'(weight_data_done), BW'(0));
      wait_done("abort");
      checkIdle("abort", 1'b0);

      $display("[TB] reset during beat");
      model_start(2, 6);
      @(negedge clk);
      fm_depth = 6'd2; kernel_num = 9'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (src_rd_en === 1'b1 && src_rd_addr == 16'd2) ok = 1'b1;
         else begin @(negedge clk); end
      end
      checkOutput("rst_sync_found", BW'(ok), BW'(1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_rd.delete();
      exp_beat.delete();
      @(negedge clk);
      check_zero("mid_reset");
      rst = 1'b1;
      applyStimulus(vecs[3], "post_reset");
      checkIdle("post_reset", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
